// File: rtl/act_if.sv
// Handshake bundle between requesters and the shared sigmoid arbiter.
// Signals: req_valid/req_data/req_ready per requester; out_valid/out_ready/out_data/out_id/out_count result side.
interface act_if #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_data;
    logic [ID_W-1:0]   out_id;
    logic [15:0]       out_count;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id, out_count
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id, out_count
    );
endinterface

// File: rtl/act_arbiter.sv
// Round-robin arbiter sharing one piecewise-quadratic sigmoid unit among NREQ requesters.
// Ports: clk, rst_n (sync, active-low), bus (act_if.slave: requests in, one-deep result slot out).
module act_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    act_if.slave  bus
);

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   ptr_nxt;
    logic [ID_W-1:0]   cand;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic              slot_free;
    logic [NREQ-1:0]   ready;
    logic signed [7:0]  x_sel;
    logic signed [15:0] y_res;

    logic              valid_q;
    logic [15:0]       data_q;
    logic [ID_W-1:0]   id_q;
    logic [15:0]       cnt_q;

    function automatic logic signed [15:0] sigmoid(input logic signed [7:0] xin);
        logic signed [15:0] xe;
        logic signed [15:0] y;
        logic signed [15:0] z;
        logic signed [15:0] s;
        logic signed [15:0] sh;
        xe = {{8{xin[7]}}, xin};
        if (xe > 16'sd64) begin
            xe = 16'sd64;
        end else if (xe < -16'sd64) begin
            xe = -16'sd64;
        end
        y  = (xe < 16'sd0) ? -xe : xe;
        z  = y >>> 2;
        s  = z - 16'sd16;
        sh = (s * s) >>> 1;
        return (xe < 16'sd0) ? sh : (16'sd256 - sh);
    endfunction

    // Search upward from ptr, wrapping at NREQ; no grant while the slot is
    // occupied and not draining, nor while reset is asserted.
    always_comb begin
        slot_free = !valid_q || bus.out_ready;
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        ready     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (int'(ptr) + k >= NREQ) begin
                cand = ID_W'(int'(ptr) + k - NREQ);
            end else begin
                cand = ID_W'(int'(ptr) + k);
            end
            if (rst_n && slot_free && !gnt_any && bus.req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_any) begin
            ready[gnt_idx] = 1'b1;
        end
    end

    assign ptr_nxt = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign x_sel   = $signed(bus.req_data[{gnt_idx, 3'b000} +: 8]);
    assign y_res   = sigmoid(x_sel);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            ptr     <= '0;
        end else begin
            if (valid_q && bus.out_ready) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (gnt_any) begin
                valid_q <= 1'b1;
                data_q  <= y_res;
                id_q    <= gnt_idx;
                ptr     <= ptr_nxt;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_id    = id_q;
    assign bus.out_count = cnt_q;

endmodule

// File: tb/tb_act_arbiter.sv
// Self-checking bench for act_arbiter: directed corner cases plus randomized traffic
// against a spec-level reference model of arbitration order and sigmoid values.
module tb_act_arbiter;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    act_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

    act_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference sigmoid from the written rules, in plain integer arithmetic.
    function automatic int sig_model(input int x);
        int xc;
        int z;
        int sh;
        xc = (x > 64) ? 64 : ((x < -64) ? -64 : x);
        z  = ((xc < 0) ? -xc : xc) / 4;
        sh = ((z - 16) * (z - 16)) / 2;
        return (xc < 0) ? sh : 256 - sh;
    endfunction

    // First valid requester at or after p, wrapping; -1 if none.
    function automatic int rr_pick(input int p, input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int lane_x(input logic [NREQ*8-1:0] d, input int i);
        logic signed [7:0] b;
        b = d[i*8 +: 8];
        return int'(b);
    endfunction

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_valid = '1;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready got %b want 0000", bus.req_ready);
        end
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'd0 ||
            bus.out_id !== 2'd0 || bus.out_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state got v=%b d=%0d id=%0d c=%0d want 0 0 0 0",
                     bus.out_valid, bus.out_data, bus.out_id, bus.out_count);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_values();
        int xs[7];
        int ys[7];
        int x;
        int want;
        int r;
        xs = '{0, 32, -32, 64, -64, 127, -128};
        ys = '{128, 224, 32, 256, 0, 256, 0};
        bus.out_ready = 1'b1;
        for (int n = 0; n < 27; n++) begin
            if (n < 7) begin
                x    = xs[n];
                want = ys[n];
            end else begin
                x    = int'($urandom_range(0, 255)) - 128;
                want = sig_model(x);
            end
            r = n % NREQ;
            bus.req_valid    = '0;
            bus.req_valid[r] = 1'b1;
            bus.req_data     = '0;
            bus.req_data[r*8 +: 8] = 8'(x);
            @(negedge clk);
            checks++;
            if (bus.req_ready !== NREQ'(1 << r)) begin
                errors++;
                $display("FAIL value_grant x=%0d got %b want lane %0d", x, bus.req_ready, r);
            end
            @(posedge clk);
            #1;
            bus.req_valid = '0;
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 16'(want) ||
                bus.out_id !== ID_W'(r)) begin
                errors++;
                $display("FAIL value x=%0d got v=%b d=%0d id=%0d want 1 %0d %0d",
                         x, bus.out_valid, $signed(bus.out_data), bus.out_id, want, r);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.out_ready = 1'b1;
        bus.req_valid = '1;
        bus.req_data  = {8'd96, 8'd32, 8'hE0, 8'd0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (bus.req_ready !== NREQ'(1 << (k % NREQ))) begin
                errors++;
                $display("FAIL rr_ready cyc=%0d got %b want lane %0d", k, bus.req_ready, k % NREQ);
            end
            if (k > 0) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_id !== ID_W'((k - 1) % NREQ)) begin
                    errors++;
                    $display("FAIL rr_id cyc=%0d got v=%b id=%0d want 1 %0d",
                             k, bus.out_valid, bus.out_id, (k - 1) % NREQ);
                end
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b0100;
        bus.req_data  = {8'hC0, 8'd32, 8'd0, 8'd0};
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_data  = {8'hE0, 8'd0, 8'd64, 8'd127};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd224 || bus.out_id !== 2'd2 ||
                bus.req_ready !== 4'b0000 || bus.out_count !== 16'd0) begin
                errors++;
                $display("FAIL hold cyc=%0d got v=%b d=%0d id=%0d rdy=%b c=%0d want 1 224 2 0000 0",
                         k, bus.out_valid, bus.out_data, bus.out_id, bus.req_ready, bus.out_count);
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL release_grant got %b want 1000", bus.req_ready);
        end
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        @(negedge clk);
        checks++;
        if (bus.out_count !== 16'd1 || bus.out_valid !== 1'b1 ||
            bus.out_id !== 2'd3 || bus.out_data !== 16'd32) begin
            errors++;
            $display("FAIL release got c=%0d v=%b id=%0d d=%0d want 1 1 3 32",
                     bus.out_count, bus.out_valid, bus.out_id, bus.out_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'd0;
        repeat (8) @(posedge clk);
        #1;
        bus.req_valid = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_count !== 16'd7) begin
            errors++;
            $display("FAIL pre_reset got v=%b c=%0d want 1 7", bus.out_valid, bus.out_count);
        end
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.req_valid = 4'b0110;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset got v=%b c=%0d want 0 0", bus.out_valid, bus.out_count);
        end
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL post_reset_grant got %b want 0010", bus.req_ready);
        end
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_count_wrap();
        do_reset();
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'd0;
        repeat (65536) @(posedge clk);
        #1;
        bus.req_valid = '0;
        @(negedge clk);
        checks++;
        if (bus.out_count !== 16'd65535 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL count_max got c=%0d v=%b want 65535 1", bus.out_count, bus.out_valid);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (bus.out_count !== 16'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL count_wrap got c=%0d v=%b want 0 0", bus.out_count, bus.out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random_traffic();
        int m_ptr;
        int m_cnt;
        int m_id;
        int m_data;
        int g;
        bit m_valid;
        bit free;
        int wait_cyc[NREQ];
        logic [NREQ-1:0] exp_rdy;
        do_reset();
        m_ptr   = 0;
        m_cnt   = 0;
        m_id    = 0;
        m_data  = 0;
        m_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) wait_cyc[i] = 0;
        for (int n = 0; n < 400; n++) begin
            rst_n         = ($urandom_range(0, 99) != 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.req_valid = NREQ'($urandom);
            bus.req_data  = $urandom;
            @(negedge clk);
            free    = !m_valid || bus.out_ready;
            g       = (rst_n && free) ? rr_pick(m_ptr, bus.req_valid) : -1;
            exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
            checks++;
            if (bus.req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rnd_ready cyc=%0d got %b want %b", n, bus.req_ready, exp_rdy);
            end
            checks++;
            if (bus.out_valid !== m_valid || bus.out_count !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL rnd_state cyc=%0d got v=%b c=%0d want %b %0d",
                         n, bus.out_valid, bus.out_count, m_valid, m_cnt);
            end
            if (m_valid) begin
                checks++;
                if (bus.out_data !== 16'(m_data) || bus.out_id !== ID_W'(m_id)) begin
                    errors++;
                    $display("FAIL rnd_result cyc=%0d got d=%0d id=%0d want %0d %0d",
                             n, $signed(bus.out_data), bus.out_id, m_data, m_id);
                end
            end
            @(posedge clk);
            if (!rst_n) begin
                m_valid = 1'b0;
                m_data  = 0;
                m_id    = 0;
                m_cnt   = 0;
                m_ptr   = 0;
            end else begin
                if (m_valid && bus.out_ready) m_cnt = (m_cnt + 1) % 65536;
                if (g >= 0) begin
                    m_valid = 1'b1;
                    m_data  = sig_model(lane_x(bus.req_data, g));
                    m_id    = g;
                    m_ptr   = (g + 1) % NREQ;
                end else if (bus.out_ready) begin
                    m_valid = 1'b0;
                end
            end
            #1;
        end
        rst_n = 1'b1;
        // Fairness: every requester holding valid is served within NREQ grants.
        bus.out_ready = 1'b1;
        bus.req_valid = '1;
        for (int n = 0; n < 3 * NREQ; n++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_ready[i]) wait_cyc[i] = 0;
                else wait_cyc[i]++;
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < NREQ; i++) begin
            checks++;
            if (wait_cyc[i] >= NREQ) begin
                errors++;
                $display("FAIL starve lane=%0d got wait=%0d want <%0d", i, wait_cyc[i], NREQ);
            end
        end
        bus.req_valid = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_values();
        test_round_robin();
        test_backpressure();
        test_reset_midstream();
        test_random_traffic();
        test_count_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/act_arbiter.md
ACT_ARBITER -- requirements
Module: act_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters sharing one sigmoid unit (legal range 2..8).
REQ-002 The block SHALL have parameter ID_W, default 2, giving the requester-ID width, equal to clog2(NREQ).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 req_valid  input  NREQ  bit i high when requester i presents an operand.
REQ-006 req_data  input  NREQ*8  requester i operand in bits [8i+7:8i], signed Q5.2 pre-activation.
REQ-007 req_ready  output  NREQ  bit i high in the cycle that requester i's operand is accepted.
REQ-008 out_valid  output  1  result register holds an unconsumed result.
REQ-009 out_ready  input  1  downstream accepts the result this cycle.
REQ-010 out_data  output  16  signed sigmoid result, Q8.8 (256 = 1.0).
REQ-011 out_id  output  ID_W  index of the requester that produced out_data.
REQ-012 out_count  output  16  count of results consumed downstream (out_valid && out_ready), wrapping.

Function
REQ-013 The output slot SHALL be free when !out_valid || out_ready.
REQ-014 In a cycle with a free slot and at least one req_valid bit set, the block SHALL grant exactly one requester: the first with req_valid set, searching from pointer ptr upward modulo NREQ.
REQ-015 req_ready SHALL be one-hot on the granted requester in the grant cycle and all-zero otherwise, including every cycle with no free slot.
REQ-016 After a grant to i, ptr SHALL become (i+1) mod NREQ; ptr SHALL hold when there is no grant.
REQ-017 Operand handling SHALL clamp x to [-64, +64] (x >= 64 -> 64; x <= -64 -> -64) before evaluation.
REQ-018 The evaluation SHALL compute:
- y = |x|
- z = y >>> 2
- s = z - 16 (signed)
- sh = (s*s) >>> 1
- result = sh if x < 0, else 256 - sh
- 16-bit signed arithmetic throughout
REQ-019 A grant in cycle t SHALL load out_data/out_id and set out_valid at edge t+1 (latency 1), sustaining one result per cycle when out_ready stays high.
REQ-020 While out_valid && !out_ready, out_data, out_id and out_valid SHALL stay unchanged, and no grant SHALL occur.
REQ-021 A consume without a new grant in the same cycle SHALL clear out_valid; a consume with a grant SHALL reload the slot with out_valid staying 1.
REQ-022 out_count SHALL increment by 1 on each consume, wrapping 65535 -> 0.
REQ-023 The req_valid-to-req_ready path SHALL be combinational; no requester SHALL be starved when it holds req_valid high (granted within NREQ grants).

Reset
REQ-024 While rst_n is low at a clock edge, the block SHALL set:
- out_valid = 0
- out_data = 0
- out_id = 0
- out_count = 0
- ptr = 0
REQ-025 During reset, req_ready SHALL be all-zero.
REQ-026 Reset asserted mid-stream SHALL discard any held result without it being counted.
REQ-027 The first grant after reset SHALL use ptr = 0.

Verification
REQ-028 Single requester, x values with out_ready = 1 -> out_data values at t+1:
- x = 0 -> 128
- x = 32 -> 224
- x = -32 -> 32
- x = 64 -> 256
- x = -64 -> 0
REQ-029 Clamp: x = 127 -> 256; x = -128 -> 0.
REQ-030 All four requesters valid continuously with out_ready = 1 -> out_id sequence 0,1,2,3,0,1..., one per cycle, and exactly one req_ready bit high per cycle.
REQ-031 out_ready low for 5 cycles with a result held -> out_data/out_id stable, req_ready all-zero, out_count unchanged; on release, consumed then next grant proceeds.
REQ-032 rst_n low for one cycle while out_valid = 1 and out_count = 7 -> next cycle out_valid = 0, out_count = 0; the next grant goes to the lowest valid index from 0.
REQ-033 Preload out_count to 65535 via 65535 consumes -> next consume gives out_count = 0.
